// File: rtl/systolic_output_collector.sv
// systolic_output_collector
// Captures the skewed bottom-edge outputs of a systolic array column by
// column, then replays the completed matrix one deskewed row at a time over
// a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; column inputs ignored
// COLLECT | each column appends valid words to its own row slot
// DRAIN   | rows presented in ascending order until the last is taken

`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module systolic_output_collector #(
  parameter int WORD_SIZE = 16,
  localparam int IW = (`ROWS > 1) ? $clog2(`ROWS) : 1,
  localparam int CW = $clog2(`ROWS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [`COLS*WORD_SIZE-1:0]   bottom_out,
  input  logic [`COLS-1:0]             output_col_valid,
  output logic [`COLS*WORD_SIZE-1:0]   out_row_data,
  output logic [IW-1:0]                out_row_idx,
  output logic                         out_row_valid,
  input  logic                         out_row_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CW-1:0] ROWS_C   = CW'(`ROWS);
  localparam logic [IW-1:0] LAST_ROW = IW'(`ROWS - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q [`COLS];
  logic [CW-1:0]        cnt_d [`COLS];
  logic [IW-1:0]        rd_row_q, rd_row_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [`COLS-1:0]     wr_en;
  logic                 all_full;

  logic [WORD_SIZE-1:0] row_buf_q [`ROWS][`COLS];

  // Next-state, per-column fill and drain handshake decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_row_d = rd_row_q;
    err_d    = err_q;
    done_d   = 1'b0;
    wr_en    = '0;
    all_full = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          for (int c = 0; c < `COLS; c++) begin
            cnt_d[c] = '0;
          end
          err_d = 1'b0;
        end
      end

      COLLECT: begin
        for (int c = 0; c < `COLS; c++) begin
          if (output_col_valid[c]) begin
            if (cnt_q[c] < ROWS_C) begin
              wr_en[c] = 1'b1;
              cnt_d[c] = cnt_q[c] + CW'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        // Judge completion on the updated counts so a column finishing this
        // very cycle still moves us to DRAIN on the next edge.
        for (int c = 0; c < `COLS; c++) begin
          if (cnt_d[c] != ROWS_C) begin
            all_full = 1'b0;
          end
        end
        if (all_full) begin
          state_d  = DRAIN;
          rd_row_d = '0;
        end
      end

      DRAIN: begin
        if (out_row_ready) begin
          if (rd_row_q == LAST_ROW) begin
            state_d  = IDLE;
            rd_row_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_row_d = rd_row_q + IW'(1);
          end
        end
      end

      default: begin
        state_d  = IDLE;
        rd_row_d = '0;
      end
    endcase

    valid_d = (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
  end

  // Control state and registered status outputs; reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_row_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int c = 0; c < `COLS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_row_q <= rd_row_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      for (int c = 0; c < `COLS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  // Result storage; contents are only ever read after being written, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < `COLS; c++) begin
      if (wr_en[c]) begin
        row_buf_q[cnt_q[c][IW-1:0]][c] <= bottom_out[c*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Present the current row; forced to zero whenever no row is offered.
  always_comb begin
    out_row_data = '0;
    if (valid_q) begin
      for (int c = 0; c < `COLS; c++) begin
        out_row_data[c*WORD_SIZE +: WORD_SIZE] = row_buf_q[rd_row_q][c];
      end
    end
  end

  assign out_row_idx   = rd_row_q;
  assign out_row_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow_err  = err_q;

endmodule

// File: tb/tb_systolic_output_collector.sv
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module tb_systolic_output_collector;
  localparam int W  = 16;
  localparam int DW = `COLS * W;
  localparam int IW = (`ROWS > 1) ? $clog2(`ROWS) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] bottom_out;
  logic [`COLS-1:0] output_col_valid;
  logic [DW-1:0] out_row_data;
  logic [IW-1:0] out_row_idx;
  logic          out_row_valid;
  logic          out_row_ready;
  logic          busy;
  logic          done;
  logic          overflow_err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  systolic_output_collector #(.WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bottom_out(bottom_out), .output_col_valid(output_col_valid),
    .out_row_data(out_row_data), .out_row_idx(out_row_idx),
    .out_row_valid(out_row_valid), .out_row_ready(out_row_ready),
    .busy(busy), .done(done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each column is a queue of accepted words; the
  // matrix is complete when every queue holds ROWS words.
  int          m_phase;  // 0 idle, 1 collecting, 2 draining
  int          m_rd;
  bit          m_err;
  bit          m_done;
  logic [W-1:0] m_q [`COLS][$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_rd = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          for (int c = 0; c < `COLS; c++) m_q[c].delete();
          m_err = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        bit full;
        for (int c = 0; c < `COLS; c++) begin
          if (output_col_valid[c]) begin
            if (m_q[c].size() < `ROWS) m_q[c].push_back(bottom_out[c*W +: W]);
            else m_err = 1;
          end
        end
        full = 1;
        for (int c = 0; c < `COLS; c++) if (m_q[c].size() != `ROWS) full = 0;
        if (full) begin m_phase = 2; m_rd = 0; end
      end else begin
        if (out_row_ready) begin
          if (m_rd == `ROWS - 1) begin m_phase = 0; m_rd = 0; m_done = 1; end
          else m_rd++;
        end
      end
    end
  end

  logic [DW-1:0] exp_data;
  logic          exp_v;
  logic [IW-1:0] exp_idx;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v    = (m_phase == 2);
      exp_data = '0;
      exp_idx  = '0;
      if (exp_v) begin
        exp_idx = IW'(m_rd);
        for (int c = 0; c < `COLS; c++) exp_data[c*W +: W] = m_q[c][m_rd];
      end
      chk("m_valid", out_row_valid, exp_v);
      chk("m_idx",   out_row_idx,   exp_idx);
      chk("m_data",  out_row_data,  exp_data);
      chk("m_busy",  busy,          (m_phase != 0));
      chk("m_done",  done,          m_done);
      chk("m_err",   overflow_err,  m_err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Drive one result matrix; word for row r, column c is base + r*16 + c.
  // skew delays column c by c cycles; extra_col gets one surplus valid.
  task automatic fill(input logic [15:0] base, input bit skew, input int extra_col);
    int ncyc;
    ncyc = skew ? (`ROWS + `COLS - 1) : `ROWS;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < `COLS; c++) begin
        int r;
        r = skew ? (k - c) : k;
        if (r >= 0 && r < `ROWS) begin
          output_col_valid[c] = 1'b1;
          bottom_out[c*W +: W] = base + 16'(r * 16 + c);
        end else if (c == extra_col && r == `ROWS) begin
          output_col_valid[c] = 1'b1;
          bottom_out[c*W +: W] = 16'hDEAD;
        end else begin
          output_col_valid[c] = 1'b0;
          bottom_out[c*W +: W] = '0;
        end
      end
      cyc();
    end
    output_col_valid = '0;
    bottom_out = '0;
  endtask

  task automatic drain_wait(input string nm);
    bit seen;
    seen = 0;
    out_row_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (done) seen = 1;
    end
    chk(nm, seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; bottom_out = '0; output_col_valid = '0; out_row_ready = 1'b0;
    chk_en = 1'b1;
    cyc(); cyc();
    chk("rst_valid", out_row_valid, 1'b0);
    chk("rst_busy",  busy,          1'b0);
    chk("rst_err",   overflow_err,  1'b0);
    rst = 1'b0;
    cyc();

    // Skewed fill, ready held high.
    out_row_ready = 1'b1;
    do_start();
    chk("start_busy", busy, 1'b1);
    fill(16'h0000, 1'b1, -1);
    chk("skew_r0_valid", out_row_valid, 1'b1);
    chk("skew_r0_idx",   out_row_idx,   2'd0);
    chk("skew_r0",       out_row_data,  64'h0003_0002_0001_0000);
    cyc();
    chk("skew_r1",       out_row_data,  64'h0013_0012_0011_0010);
    cyc();
    chk("skew_r2",       out_row_data,  64'h0023_0022_0021_0020);
    cyc();
    chk("skew_r3",       out_row_data,  64'h0033_0032_0031_0030);
    chk("skew_r3_idx",   out_row_idx,   2'd3);
    chk("skew_nodone",   done,          1'b0);
    cyc();
    chk("skew_done",     done,          1'b1);
    chk("skew_post_v",   out_row_valid, 1'b0);
    cyc();
    chk("skew_done_1cy", done,          1'b0);

    // Backpressure on row 1.
    out_row_ready = 1'b0;
    do_start();
    fill(16'h0100, 1'b1, -1);
    out_row_ready = 1'b1;
    cyc();
    out_row_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_idx_hold",  out_row_idx,  2'd1);
      chk("bp_data_hold", out_row_data, 64'h0113_0112_0111_0110);
      cyc();
    end
    chk("bp_idx_after", out_row_idx, 2'd1);
    out_row_ready = 1'b1;
    cyc();
    chk("bp_r2", out_row_data, 64'h0123_0122_0121_0120);
    cyc();
    chk("bp_r3_nodone", done, 1'b0);
    cyc();
    chk("bp_done", done, 1'b1);
    out_row_ready = 1'b0;

    // Column inputs in IDLE are ignored.
    output_col_valid = '1;
    bottom_out = {`COLS{16'hBEEF}};
    cyc(); cyc();
    chk("idle_ign_busy", busy, 1'b0);
    chk("idle_ign_err",  overflow_err, 1'b0);
    output_col_valid = '0;
    bottom_out = '0;

    // Start and valids during DRAIN are ignored.
    do_start();
    fill(16'h0300, 1'b1, -1);
    start = 1'b1;
    output_col_valid = '1;
    bottom_out = {`COLS{16'hBAD0}};
    cyc(); cyc();
    start = 1'b0;
    output_col_valid = '0;
    bottom_out = '0;
    chk("drain_ign_busy", busy, 1'b1);
    chk("drain_ign_idx",  out_row_idx, 2'd0);
    chk("drain_ign_data", out_row_data, 64'h0303_0302_0301_0300);
    chk("drain_ign_err",  overflow_err, 1'b0);
    drain_wait("drain_ign_done");
    out_row_ready = 1'b0;
    cyc();

    // Overflow on column 2.
    do_start();
    fill(16'h0200, 1'b1, 2);
    chk("ovf_err",  overflow_err, 1'b1);
    chk("ovf_r0",   out_row_data, 64'h0203_0202_0201_0200);
    out_row_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("ovf_r3",   out_row_data, 64'h0233_0232_0231_0230);
    cyc();
    chk("ovf_done", done, 1'b1);
    chk("ovf_sticky", overflow_err, 1'b1);
    out_row_ready = 1'b0;
    do_start();
    chk("ovf_clear", overflow_err, 1'b0);

    // Simultaneous completion on all columns.
    fill(16'h0400, 1'b0, -1);
    chk("sim_valid", out_row_valid, 1'b1);
    chk("sim_idx",   out_row_idx,   2'd0);
    chk("sim_r0",    out_row_data,  64'h0403_0402_0401_0400);
    drain_wait("sim_done");
    out_row_ready = 1'b0;

    // Reset mid-DRAIN after rows 0 and 1 transferred.
    do_start();
    fill(16'h0500, 1'b1, -1);
    out_row_ready = 1'b1;
    cyc(); cyc();
    out_row_ready = 1'b0;
    chk("rstd_idx_pre", out_row_idx, 2'd2);
    #1 rst = 1'b1;
    #1;
    chk("rstd_valid", out_row_valid, 1'b0);
    chk("rstd_busy",  busy,          1'b0);
    chk("rstd_idx",   out_row_idx,   2'd0);
    chk("rstd_data",  out_row_data,  64'h0);
    chk("rstd_done",  done,          1'b0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("rstd_idle", busy, 1'b0);
    out_row_ready = 1'b1;
    do_start();
    fill(16'h0600, 1'b1, -1);
    chk("rstd_r0",     out_row_data, 64'h0603_0602_0601_0600);
    chk("rstd_r0_idx", out_row_idx,  2'd0);
    drain_wait("rstd_done2");
    cyc();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_output_collector.md
SYSTOLIC_OUTPUT_COLLECTOR -- requirements
Module: systolic_output_collector

Interface
REQ-001 Parameter: WORD_SIZE, default 16, bit width of one result element.
REQ-002 Array dimensions SHALL be taken from header macros `ROWS and `COLS (bench default 4 and 4); no other dimension parameters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; arms collection of a new result matrix.
REQ-006 bottom_out  input  `COLS*WORD_SIZE  systolic array bottom outputs; column c occupies bits [c*WORD_SIZE +: WORD_SIZE].
REQ-007 output_col_valid  input  `COLS  bit c high means column c of bottom_out holds a valid product this cycle.
REQ-008 out_row_data  output  `COLS*WORD_SIZE  one deskewed result row, same column packing as bottom_out.
REQ-009 out_row_idx  output  max(1,$clog2(`ROWS))  row index of out_row_data.
REQ-010 out_row_valid  output  1  out_row_data and out_row_idx valid.
REQ-011 out_row_ready  input  1  consumer accepts the row when high together with out_row_valid.
REQ-012 busy  output  1  high in COLLECT or DRAIN.
REQ-013 done  output  1  one-cycle pulse after the last row is accepted.
REQ-014 overflow_err  output  1  sticky; a valid arrived on a full column.

Function
REQ-015 State machine states: IDLE, COLLECT, DRAIN.
REQ-016 Storage: `ROWS x `COLS WORD_SIZE-bit buffer plus one row counter per column, width $clog2(`ROWS)+1.
REQ-017 IDLE: start=1 -> clear all column counters and overflow_err, go COLLECT next cycle; start in COLLECT or DRAIN is ignored.
REQ-018 COLLECT: per column c each cycle, if output_col_valid[c]=1 and cnt[c]<`ROWS -> buffer[cnt[c]][c] <= bottom_out word c, cnt[c] <= cnt[c]+1; columns are independent and may write in the same cycle.
REQ-019 COLLECT: output_col_valid[c]=1 with cnt[c]==`ROWS -> data dropped, overflow_err <= 1, held until the next accepted start or reset.
REQ-020 COLLECT -> DRAIN on the cycle after all cnt[c]==`ROWS, including completion by same-cycle writes; rd_row <= 0.
REQ-021 DRAIN: out_row_valid=1; out_row_data = buffer[rd_row] (registered or combinational from the buffer); out_row_idx = rd_row.
REQ-022 Handshake: row transfers on a rising edge with out_row_valid and out_row_ready both high; data and idx SHALL remain stable while valid=1 and ready=0.
REQ-023 Transfer with rd_row<`ROWS-1 -> rd_row+1; transfer with rd_row==`ROWS-1 -> IDLE, done=1 for exactly one cycle, out_row_valid=0.
REQ-024 Column inputs are ignored in IDLE and DRAIN: no buffer write, no overflow_err.
REQ-025 Latency: first row valid one cycle after the final column write; throughput one row per cycle with ready held high.
REQ-026 Rows are delivered in ascending index; element [r][c] is the r-th valid word seen on column c since start.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, clear counters and rd_row, and force out_row_valid, busy, done, overflow_err and out_row_idx to 0, including mid-COLLECT or mid-DRAIN.
REQ-028 Buffer contents need no reset; out_row_data SHALL read 0 while out_row_valid=0.
REQ-029 After rst deasserts, the block waits in IDLE for start.

Verification
REQ-030 Skewed fill, 4x4: start; column c valid for 4 cycles starting c cycles later, word = 16'h(r*16+c) -> rows 0..3 out as {03,02,01,00},{13,12,11,10},... with ready=1, done on the cycle after row 3.
REQ-031 Backpressure: ready low 3 cycles with row 1 presented -> row 1 data and idx=1 held stable, no skip or repeat, done only after 4 transfers.
REQ-032 Overflow: column 2 asserts valid a 5th time during COLLECT -> overflow_err=1, row data unchanged; a new start clears it.
REQ-033 Reset mid-DRAIN after row 1 -> outputs 0 in the same cycle, IDLE; a subsequent start plus fill yields correct rows from 0.
REQ-034 Ignored inputs: start pulsed in DRAIN and valids driven in IDLE -> no state change, no buffer corruption, overflow_err stays 0.
REQ-035 Simultaneous completion: all 4 columns take their 4th word in the same cycle -> DRAIN entered the next cycle, row 0 valid.
